// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for NUM_INIT bus initiators plus one split-return target.
// Optional hold-time limit per initiator is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
   parameter int NUM_INIT       = 4,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int IW            = $clog2(NUM_INIT)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_INIT-1:0] req,
   input  logic                req_split,
   input  logic                split_event,
   output logic [NUM_INIT-1:0] grant,
   output logic                grant_split,
   output logic [IW-1:0]       grant_id,
   output logic                split_pending,
   output logic                split,
   output logic                timeout
);

   typedef enum logic [1:0] {IDLE, OWN_INIT, OWN_SPLIT} state_t;

   state_t              state;
   logic [IW-1:0]       last;
   logic [IW-1:0]       split_owner;
   logic [NUM_INIT-1:0] eligible;
   logic [IW-1:0]       winner;
   logic                found;
   int                  scan_idx;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] HOLD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]         hold_cnt;
   logic [NUM_INIT-1:0] blocked;
`endif

   // The parked split owner, and any initiator cut off by the hold limit, sit out arbitration.
   always_comb begin
      eligible = req;
      if (split_pending) eligible[split_owner] = 1'b0;
`ifdef ARB_TIMEOUT_EN
      eligible = eligible & ~blocked;
`endif
   end

   always_comb begin
      found    = 1'b0;
      winner   = last;
      scan_idx = 0;
      for (int k = 1; k <= NUM_INIT; k++) begin
         scan_idx = int'(last) + k;
         if (scan_idx >= NUM_INIT) scan_idx = scan_idx - NUM_INIT;
         if (!found && eligible[IW'(scan_idx)]) begin
            found  = 1'b1;
            winner = IW'(scan_idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant         <= '0;
         grant_split   <= 1'b0;
         grant_id      <= '0;
         split_pending <= 1'b0;
         split_owner   <= '0;
         last          <= IW'(NUM_INIT - 1);
`ifdef ARB_TIMEOUT_EN
         hold_cnt      <= '0;
         blocked       <= '0;
         timeout       <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout <= 1'b0;
         blocked <= blocked & req;
`endif
         case (state)
            IDLE: begin
               if (req_split && split_pending) begin
                  grant_split <= 1'b1;
                  state       <= OWN_SPLIT;
               end else if (found) begin
                  grant         <= '0;
                  grant[winner] <= 1'b1;
                  grant_id      <= winner;
                  last          <= winner;
                  state         <= OWN_INIT;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt      <= '0;
`endif
               end
            end
            OWN_INIT: begin
               // A split wins over a simultaneous request drop.
               if (split_event) begin
                  split_pending <= 1'b1;
                  split_owner   <= grant_id;
                  grant         <= '0;
                  state         <= IDLE;
               end else if (!req[grant_id]) begin
                  grant <= '0;
                  state <= IDLE;
               end
`ifdef ARB_TIMEOUT_EN
               else if (hold_cnt == HOLD_LAST) begin
                  grant             <= '0;
                  timeout           <= 1'b1;
                  last              <= grant_id;
                  blocked[grant_id] <= 1'b1;
                  state             <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 16'd1;
               end
`endif
            end
            OWN_SPLIT: begin
               if (!req_split) begin
                  grant_split   <= 1'b0;
                  split_pending <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

   assign split = grant_split;

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
Parametrised serial-bus arbiter that generalises the fixed two-initiator arbiter to NUM_INIT initiators.
- Fair round-robin selection among initiators.
- Tracks split transactions: the split initiator is parked and the split target gets priority to return data.
- Sits between all init_port arbiter_req/arbiter_grant pairs, the split_target_port arbiter_split_req, and the address decoder's split input.

Parameters:
NUM_INIT, 4, number of initiator request/grant pairs (legal range 2..16)
TIMEOUT_CYCLES, 64, maximum cycles one initiator may hold the grant; used only when ARB_TIMEOUT_EN is defined (legal range 2..65535)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req  input  NUM_INIT  per-initiator bus request, level, bit i = initiator i
req_split  input  1  split target request to return data
split_event  input  1  one-cycle pulse from target: current transaction has been split
grant  output  NUM_INIT  one-hot initiator grant, registered
grant_split  output  1  grant to split target, registered
grant_id  output  $clog2(NUM_INIT)  index of current/last initiator owner
split_pending  output  1  a split transaction is outstanding
split  output  1  to address decoder; equals grant_split
timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (rst_n=0 sampled at clk edge):
  - grant=0, grant_split=0, split_pending=0, timeout=0, grant_id=0.
  - RR pointer last=NUM_INIT-1, state=IDLE, split_owner=0.
  - Reset mid-transaction drops every grant on that edge.
- FSM states: IDLE, OWN_INIT, OWN_SPLIT.
- IDLE:
  - If req_split && split_pending: go to OWN_SPLIT, grant_split=1 next edge. Split return has absolute priority.
  - Else if any eligible req: winner = first eligible index scanning last+1, last+2, … modulo NUM_INIT. grant[winner]=1 next edge, grant_id=winner, last=winner, go to OWN_INIT.
  - Eligible = req[i]=1 and not (split_pending && i==split_owner).
  - req_split while split_pending=0 is ignored.
- Grant latency: a request sampled in IDLE gives a grant on the following edge (1 cycle). Grants are never combinational.
- OWN_INIT:
  - Hold grant while req[grant_id]=1.
  - req[grant_id]=0 sampled: grant=0 next edge, go to IDLE. This forces at least one all-zero grant cycle (turnaround) before any new grant.
  - split_event=1: split_pending=1, split_owner=grant_id, grant=0 next edge, go to IDLE. split_event takes precedence over a simultaneous req drop.
- OWN_SPLIT:
  - Hold grant_split while req_split=1.
  - On drop: grant_split=0 and split_pending=0 next edge, go to IDLE.
  - The former split owner becomes eligible again from that IDLE cycle.
- split_event outside OWN_INIT is ignored. A second split while split_pending=1 cannot occur, because the split owner is masked and only one split target is supported.
- At most one bit of {grant, grant_split} is set in any cycle. The verification engineer asserts this invariant.
- grant_id holds its value in IDLE.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - A 16-bit hold counter clears on entry to OWN_INIT and increments each OWN_INIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 with req still high: grant drops next edge, timeout pulses 1 cycle, last=grant_id, go to IDLE.
  - That initiator stays ineligible until it deasserts req for at least one cycle.
  - OWN_SPLIT is never timed out.
- Undefined: no counter is built, timeout is tied 0, and an owner holds the bus indefinitely.

Test Plan:
- Reset, req=4'b0001 from cycle 0 → grant=4'b0001 on the 1st edge after sampling, grant_id=0; req drops → grant=0 next edge.
- req=4'b1111 held; each owner drops req after 3 granted cycles, then reasserts it in the idle cycle → grant order 0,1,2,3,0 with exactly one zero-grant cycle between owners.
- Owner 2 granted, split_event pulse → grant=0 next edge, split_pending=1; req=4'b0100 stays masked while req=4'b0001 is granted; then req_split=1 → grant_split=1, split=1; req_split=0 → split_pending=0, initiator 2 granted next.
- Simultaneous req=4'b0010 and req_split=1 in IDLE with split_pending=1 → grant_split wins; initiator 1 is granted after split release.
- rst_n=0 while grant=4'b1000 → all outputs 0 on that edge; after release with req=4'b1000 → initiator 3 is re-granted.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, req[0] held high → grant[0] high for exactly 8 cycles, timeout pulse, initiator 1 (req=1) granted next; initiator 0 is not regranted until its req toggles low.
